// File: rtl/fetch_seq_ctrl.sv
// PC / instruction-fetch sequencer: single-outstanding req/gnt/rvalid fetch with hazard hold,
// redirect squash and halt. Optional stall counter output when FETCH_PERF_CNT_EN is defined.
module fetch_seq_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic        redirect,
  input  logic        hazard_stall,
  input  logic        halt,
  output logic        stay,
  output logic        if_valid,
  output logic        flush,
  output logic        timeout_err,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        busy
);

  localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    StIdle, StReq, StWait, StAdv, StHold, StFlush, StHalt
  } state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                redir_pend_q, redir_pend_d;
  logic                halt_pend_q, halt_pend_d;
  logic                tmo_q, tmo_d;
  logic                halt_seen;
  logic                stay_q, req_q, if_valid_q, flush_q, busy_q;

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    redir_pend_d = redir_pend_q;
    halt_pend_d  = halt_pend_q;
    tmo_d        = tmo_q;
    halt_seen    = halt | halt_pend_q;
    unique case (state_q)
      StIdle, StReq: begin
        if (halt) begin
          state_d      = StHalt;
          redir_pend_d = 1'b0;
        end else begin
          if (redirect) redir_pend_d = 1'b1;
          if (state_q == StIdle) begin
            state_d = StReq;
          end else if (imem_gnt) begin
            state_d     = StWait;
            wcnt_d      = '0;
            halt_pend_d = 1'b0;
          end
        end
      end
      StWait: begin
        // The outstanding fetch must complete, so halt/redirect are latched here
        wcnt_d = wcnt_q + WCNT_W'(1);
        if (halt) halt_pend_d = 1'b1;
        if (halt_seen) redir_pend_d = 1'b0;
        else if (redirect) redir_pend_d = 1'b1;
        if (imem_rvalid) begin
          if (halt_seen)                      state_d = StHalt;
          else if (redirect || redir_pend_q)  state_d = StFlush;
          else if (hazard_stall)              state_d = StHold;
          else                                state_d = StAdv;
        end else if (wcnt_q == WCNT_W'(MAX_WAIT - 1)) begin
          tmo_d   = 1'b1;
          state_d = StHalt;
        end
      end
      StAdv: begin
        if (halt)          state_d = StHalt;
        else if (redirect) state_d = StFlush;
        else               state_d = StReq;
      end
      StHold: begin
        if (halt)               state_d = StHalt;
        else if (redirect)      state_d = StFlush;
        else if (!hazard_stall) state_d = StAdv;
      end
      StFlush: begin
        if (halt) begin
          state_d      = StHalt;
          redir_pend_d = 1'b0;
        end else begin
          state_d      = StReq;
          redir_pend_d = redirect;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered decodes of the next state, so they track state_q exactly
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      wcnt_q       <= '0;
      redir_pend_q <= 1'b0;
      halt_pend_q  <= 1'b0;
      tmo_q        <= 1'b0;
      stay_q       <= 1'b1;
      req_q        <= 1'b0;
      if_valid_q   <= 1'b0;
      flush_q      <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      redir_pend_q <= redir_pend_d;
      halt_pend_q  <= halt_pend_d;
      tmo_q        <= tmo_d;
      stay_q       <= !((state_d == StAdv) || (state_d == StFlush));
      req_q        <= (state_d == StReq);
      if_valid_q   <= (state_d == StAdv) || (state_d == StHold);
      flush_q      <= (state_d == StFlush);
      busy_q       <= (state_d != StHalt);
    end
  end

  assign imem_req    = req_q;
  assign stay        = stay_q;
  assign if_valid    = if_valid_q;
  assign flush       = flush_q;
  assign timeout_err = tmo_q;
  assign busy        = busy_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q;

  // REQ, WAIT and HOLD are exactly the non-idle, non-halted states that hold the PC
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if ((state_q == StReq) || (state_q == StWait) || (state_q == StHold)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed, table-driven bench for fetch_seq_ctrl plus hand sequences for timeout,
// latched halt and asynchronous reset.
module tb_fetch_seq_ctrl;

  logic clk = 1'b0;
  logic rstn;
  logic imem_req, imem_gnt, imem_rvalid, redirect, hazard_stall, halt;
  logic stay, if_valid, flush, timeout_err, busy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // Output code {stay, imem_req, if_valid, flush, timeout_err, busy}
  localparam logic [5:0] O_IDLE  = 6'b100001;
  localparam logic [5:0] O_REQ   = 6'b110001;
  localparam logic [5:0] O_WAIT  = 6'b100001;
  localparam logic [5:0] O_ADV   = 6'b001001;
  localparam logic [5:0] O_HOLD  = 6'b101001;
  localparam logic [5:0] O_FLUSH = 6'b000101;
  localparam logic [5:0] O_HALT  = 6'b100000;
  localparam logic [5:0] O_TMO   = 6'b100010;

  // Input code {imem_gnt, imem_rvalid, redirect, hazard_stall, halt}
  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_GNT  = 5'b10000;
  localparam logic [4:0] I_RV   = 5'b01000;
  localparam logic [4:0] I_GR   = 5'b11000;
  localparam logic [4:0] I_RED  = 5'b00100;
  localparam logic [4:0] I_HAZ  = 5'b00010;
  localparam logic [4:0] I_HALT = 5'b00001;

  typedef struct packed {
    logic [4:0] in;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  fetch_seq_ctrl #(.MAX_WAIT(16)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .imem_req     (imem_req),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .redirect     (redirect),
    .hazard_stall (hazard_stall),
    .halt         (halt),
    .stay         (stay),
    .if_valid     (if_valid),
    .flush        (flush),
    .timeout_err  (timeout_err),
`ifdef FETCH_PERF_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {stay, imem_req, if_valid, flush, timeout_err, busy};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b (stay,req,ifv,flush,tmo,busy)", name, got, exp);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic check_perf(input string name, input logic [31:0] exp);
    checks++;
    if (stall_cycles !== exp) begin
      errors++;
      $display("FAIL %s stall_cycles got %0d want %0d", name, stall_cycles, exp);
    end
  endtask
`endif

  // Drive one cycle of inputs and sample 1ns after the edge
  task automatic step(input logic [4:0] in, input logic [5:0] exp, input string name);
    {imem_gnt, imem_rvalid, redirect, hazard_stall, halt} = in;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  // Called 1ns after an edge: pulse rstn low for 3ns between edges
  task automatic async_rst(input string name);
    #1;
    rstn = 1'b0;
    #1;
    check(name, O_IDLE);
`ifdef FETCH_PERF_CNT_EN
    check_perf({name, "_perf"}, 32'd0);
`endif
    #2;
    rstn = 1'b1;
  endtask

  task automatic add(input logic [4:0] in, input logic [5:0] exp);
    vecs.push_back({in, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero-wait fetches: ADV every 3rd cycle
    for (int k = 0; k < 4; k++) begin
      add(I_GR, O_REQ); add(I_GR, O_WAIT); add(I_GR, O_ADV);
    end
    // rvalid 5 cycles late
    add(I_GNT, O_REQ); add(I_GNT, O_WAIT);
    for (int k = 0; k < 5; k++) add(I_NONE, O_WAIT);
    add(I_RV, O_ADV);
    // Hazard on response: four HOLD cycles then one ADV
    add(I_NONE, O_REQ); add(I_GNT, O_WAIT); add(I_RV | I_HAZ, O_HOLD);
    for (int k = 0; k < 3; k++) add(I_HAZ, O_HOLD);
    add(I_NONE, O_ADV);
    // Redirect during REQ discards the next response
    add(I_NONE, O_REQ); add(I_RED, O_REQ); add(I_GNT, O_WAIT); add(I_RV, O_FLUSH);
    add(I_NONE, O_REQ);
    // Redirect beats hazard in HOLD
    add(I_GNT, O_WAIT); add(I_RV | I_HAZ, O_HOLD); add(I_RED | I_HAZ, O_FLUSH);
    add(I_NONE, O_REQ);
    // Halt beats redirect; HALT is terminal
    add(I_GNT, O_WAIT); add(I_RV, O_ADV); add(I_RED | I_HALT, O_HALT);
    add(I_GR | I_RED, O_HALT); add(I_NONE, O_HALT);

    rstn = 1'b0;
    {imem_gnt, imem_rvalid, redirect, hazard_stall, halt} = I_NONE;
    repeat (2) @(posedge clk);
    #1;
    check("reset", O_IDLE);
`ifdef FETCH_PERF_CNT_EN
    check_perf("reset_perf", 32'd0);
`endif
    rstn = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].in, vecs[i].exp, $sformatf("vec[%0d]", i));
`ifdef FETCH_PERF_CNT_EN
      if (i == 2) check_perf("perf_one_fetch", 32'd2);
`endif
    end

    // Timeout: 16 WAIT cycles without rvalid
    async_rst("rst_from_halt");
    step(I_GNT, O_REQ, "tmo_req");
    step(I_GNT, O_WAIT, "tmo_wait_entry");
    for (int k = 1; k <= 16; k++)
      step(I_NONE, (k < 16) ? O_WAIT : O_TMO, $sformatf("tmo_wait%0d", k));
    step(I_GR, O_TMO, "tmo_sticky0");
    step(I_RV, O_TMO, "tmo_sticky1");

    // Halt in WAIT is held until the response arrives
    async_rst("rst_clears_tmo");
    step(I_NONE, O_REQ, "hl_req");
    step(I_GNT, O_WAIT, "hl_wait");
    step(I_HALT, O_WAIT, "hl_latched");
    step(I_NONE, O_WAIT, "hl_still_wait");
    step(I_RV, O_HALT, "hl_halt_on_rvalid");

    // Reset mid-WAIT abandons the fetch; a fresh fetch follows
    async_rst("rst_from_halt2");
    step(I_NONE, O_REQ, "mw_req");
    step(I_GNT, O_WAIT, "mw_wait");
    async_rst("rst_mid_wait");
    step(I_RV, O_REQ, "mw_after_rst");
    async_rst("rst_mid_req");
    step(I_GR, O_REQ, "mw2_req");
    step(I_GR, O_WAIT, "mw2_wait");
    step(I_GR, O_ADV, "mw2_adv");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
